// File: rtl/vga_image_streamer.sv
// Avalon-ST frame source streaming stored images from one block ROM, switching images only at frame boundaries.
// Optional VGA_TEST_PATTERN_EN adds a test_pattern input that replaces the ROM image with 8 vertical colour bars.
module vga_image_streamer #(
    parameter int    H_RES      = 640,
    parameter int    V_RES      = 480,
    parameter int    NUM_IMAGES = 3,
    parameter int    CH_BITS    = 1,
    parameter string INIT_FILE  = "images.hex",
    parameter int    SEL_W      = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] image_sel,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_pattern,
`endif
    output logic [29:0]      data,
    output logic             startofpacket,
    output logic             endofpacket,
    output logic             valid,
    input  logic             ready,
    output logic [15:0]      frame_count
);

    localparam int PIX   = H_RES * V_RES;
    localparam int DEPTH = NUM_IMAGES * PIX;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int W     = 3 * CH_BITS;
    localparam logic [IW-1:0] LAST = IW'(PIX - 1);

    typedef enum logic [0:0] {PRIME, STREAM} state_t;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   idx_next_s;
    logic [SEL_W-1:0] cur_img_r;
    logic            black_r;
    logic [15:0]     frame_count_r;
    logic            valid_r;
    logic            sop_r;
    logic            eop_r;
    logic            rom_en_s;
    logic [AW-1:0]   rom_addr_s;
    logic [W-1:0]    rom_q_r;
    logic            xfer_s;
    logic            wrap_s;
    logic [7:0]      r8_s;
    logic [7:0]      g8_s;
    logic [7:0]      b8_s;

    logic [W-1:0]    rom_r [DEPTH];

    // An out-of-range image maps to word 0; its frame is blanked downstream anyway.
    function automatic logic [AW-1:0] img_base(input logic [SEL_W-1:0] sel);
        if (32'(sel) < NUM_IMAGES) begin
            img_base = AW'(32'(sel) * PIX);
        end else begin
            img_base = '0;
        end
    endfunction

    // Replicate the channel value MSB-first until 8 bits are filled.
    function automatic logic [7:0] expand(input logic [CH_BITS-1:0] c);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[CH_BITS-1-(i % CH_BITS)];
        end
        return e;
    endfunction

    assign xfer_s = valid_r & ready;
    assign wrap_s = xfer_s & (idx_r == LAST);

    // Next pixel index and ROM read request for the coming edge.
    always_comb begin
        rom_en_s   = 1'b0;
        rom_addr_s = '0;
        idx_next_s = idx_r;
        case (state_r)
            PRIME: begin
                rom_en_s   = 1'b1;
                idx_next_s = '0;
                rom_addr_s = img_base(image_sel);
            end
            STREAM: begin
                if (wrap_s) begin
                    rom_en_s   = 1'b1;
                    idx_next_s = '0;
                    rom_addr_s = img_base(image_sel);
                end else if (xfer_s) begin
                    rom_en_s   = 1'b1;
                    idx_next_s = idx_r + 1'b1;
                    rom_addr_s = img_base(cur_img_r) + AW'(idx_next_s);
                end else begin
                    rom_en_s   = 1'b0;
                end
            end
            default: begin
                rom_en_s = 1'b0;
            end
        endcase
    end

    // Synchronous-read image ROM.
    always_ff @(posedge clk) begin
        if (rom_en_s) begin
            rom_q_r <= rom_r[rom_addr_s];
        end
    end

    // Stream control FSM; image selection is latched only at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= PRIME;
            idx_r         <= '0;
            cur_img_r     <= '0;
            black_r       <= 1'b0;
            frame_count_r <= 16'd0;
            valid_r       <= 1'b0;
            sop_r         <= 1'b0;
            eop_r         <= 1'b0;
        end else begin
            case (state_r)
                PRIME: begin
                    cur_img_r <= image_sel;
                    black_r   <= (32'(image_sel) >= NUM_IMAGES);
                    idx_r     <= idx_next_s;
                    sop_r     <= 1'b1;
                    eop_r     <= (idx_next_s == LAST);
                    valid_r   <= 1'b1;
                    state_r   <= STREAM;
                end
                STREAM: begin
                    if (xfer_s) begin
                        idx_r <= idx_next_s;
                        sop_r <= (idx_next_s == '0);
                        eop_r <= (idx_next_s == LAST);
                    end
                    if (wrap_s) begin
                        cur_img_r     <= image_sel;
                        black_r       <= (32'(image_sel) >= NUM_IMAGES);
                        frame_count_r <= frame_count_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= PRIME;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int CW    = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int BAR_W = (H_RES >= 8) ? (H_RES / 8) : 1;
    localparam logic [CW-1:0] HLAST = CW'(H_RES - 1);

    logic          tp_r;
    logic [CW-1:0] col_r;
    int unsigned   bar_s;
    logic [2:0]    bar_k_s;

    // Pattern flag and presented column, tracked alongside the pixel index.
    always_ff @(posedge clk) begin
        if (reset) begin
            tp_r  <= 1'b0;
            col_r <= '0;
        end else if (state_r == PRIME) begin
            tp_r  <= test_pattern;
            col_r <= '0;
        end else if (xfer_s) begin
            col_r <= (col_r == HLAST) ? '0 : col_r + 1'b1;
            if (wrap_s) begin
                tp_r <= test_pattern;
            end
        end
    end

    // Bar number of the presented column.
    always_comb begin
        bar_s   = 32'(col_r) / BAR_W;
        bar_k_s = (bar_s > 32'd7) ? 3'd7 : bar_s[2:0];
    end
`endif

    // Colour expansion of the presented ROM word, with blanking or bars overriding it.
    always_comb begin
        r8_s = expand(rom_q_r[3*CH_BITS-1 -: CH_BITS]);
        g8_s = expand(rom_q_r[2*CH_BITS-1 -: CH_BITS]);
        b8_s = expand(rom_q_r[CH_BITS-1:0]);
`ifdef VGA_TEST_PATTERN_EN
        if (tp_r) begin
            r8_s = {8{bar_k_s[2]}};
            g8_s = {8{bar_k_s[1]}};
            b8_s = {8{bar_k_s[0]}};
        end else if (black_r) begin
            r8_s = 8'd0;
            g8_s = 8'd0;
            b8_s = 8'd0;
        end else begin
            r8_s = r8_s;
        end
`else
        if (black_r) begin
            r8_s = 8'd0;
            g8_s = 8'd0;
            b8_s = 8'd0;
        end else begin
            r8_s = r8_s;
        end
`endif
    end

    assign data          = {r8_s, 2'b00, g8_s, 2'b00, b8_s, 2'b00};
    assign startofpacket = sop_r;
    assign endofpacket   = eop_r;
    assign valid         = valid_r;
    assign frame_count   = frame_count_r;

endmodule

// File: tb/tb_vga_image_streamer.sv
// Directed self-checking bench for vga_image_streamer: small 4x2 two-image stream plus a CH_BITS=3 expansion instance.
module tb_vga_image_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  image_sel;
    logic        ready;
    logic [29:0] data;
    logic        sop, eop, valid;
    logic [15:0] frame_count;

    logic        ready1;
    logic [0:0]  image_sel1;
    logic [29:0] data1;
    logic        sop1, eop1, valid1;
    logic [15:0] frame_count1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_image_streamer #(
        .H_RES(4), .V_RES(2), .NUM_IMAGES(2), .CH_BITS(1), .INIT_FILE(""), .SEL_W(2)
    ) dut0 (
        .clk(clk), .reset(reset), .image_sel(image_sel),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern(1'b0),
`endif
        .data(data), .startofpacket(sop), .endofpacket(eop),
        .valid(valid), .ready(ready), .frame_count(frame_count)
    );

    vga_image_streamer #(
        .H_RES(8), .V_RES(1), .NUM_IMAGES(1), .CH_BITS(3), .INIT_FILE("")
    ) dut1 (
        .clk(clk), .reset(reset), .image_sel(image_sel1),
`ifdef VGA_TEST_PATTERN_EN
        .test_pattern(1'b0),
`endif
        .data(data1), .startofpacket(sop1), .endofpacket(eop1),
        .valid(valid1), .ready(ready1), .frame_count(frame_count1)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic        ready2;
    logic [29:0] data2;
    logic        sop2, eop2, valid2;
    logic [15:0] frame_count2;

    vga_image_streamer #(
        .H_RES(8), .V_RES(1), .NUM_IMAGES(1), .CH_BITS(3), .INIT_FILE("")
    ) dut2 (
        .clk(clk), .reset(reset), .image_sel(1'b0), .test_pattern(1'b1),
        .data(data2), .startofpacket(sop2), .endofpacket(eop2),
        .valid(valid2), .ready(ready2), .frame_count(frame_count2)
    );
`endif

    function automatic logic [29:0] px(input logic r, input logic g, input logic b);
        return {{8{r}}, 2'b00, {8{g}}, 2'b00, {8{b}}, 2'b00};
    endfunction

    // kind 0: image 0 (white), kind 1: image 1 (word = pixel index), other: black
    function automatic logic [29:0] expect_beat(input int kind, input int p);
        logic [2:0] v;
        v = 3'(p);
        case (kind)
            0:       return px(1'b1, 1'b1, 1'b1);
            1:       return px(v[2], v[1], v[0]);
            default: return 30'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk one frame under a ready pattern; stops early before accepting beat stop_beat (if >= 0).
    task automatic run_frame(input int kind, input logic [15:0] rpat, input int chg_beat,
                             input logic [1:0] new_sel, input int stop_beat);
        int b;
        int cyc;
        b = 0;
        cyc = 0;
        while (b < 8 && b != stop_beat && cyc < 64) begin
            ready = rpat[cyc % 16];
            if (b == chg_beat) image_sel = new_sel;
            chk($sformatf("valid k%0d b%0d", kind, b), 32'(valid), 32'd1);
            chk($sformatf("data k%0d b%0d", kind, b), 32'(data), 32'(expect_beat(kind, b)));
            chk($sformatf("sop k%0d b%0d", kind, b), 32'(sop), 32'(b == 0));
            chk($sformatf("eop k%0d b%0d", kind, b), 32'(eop), 32'(b == 7));
            step();
            if (ready) b++;
            cyc++;
        end
        chk("beats_within_budget", 32'(b), (stop_beat < 0) ? 32'd8 : 32'(stop_beat));
    endtask

    initial begin
        reset      = 1'b1;
        ready      = 1'b1;
        image_sel  = 2'd0;
        ready1     = 1'b0;
        image_sel1 = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        ready2     = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            dut0.rom_r[i]     = 3'b111;
            dut0.rom_r[8 + i] = 3'(i);
            dut1.rom_r[i]     = 9'd0;
        end
        dut1.rom_r[0] = 9'b101_011_001;

        step();
        step();
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset frame_count", 32'(frame_count), 32'd0);
        chk("reset valid1", 32'(valid1), 32'd0);

        reset = 1'b0;
        chk("valid still low before prime edge", 32'(valid), 32'd0);
        step();
        chk("ch3 valid", 32'(valid1), 32'd1);
        chk("ch3 data", 32'(data1), 32'({8'hB6, 2'b00, 8'h6D, 2'b00, 8'h24, 2'b00}));
        chk("ch3 sop", 32'(sop1), 32'd1);

        // Frame 0: white, request image 1 mid-frame.
        run_frame(0, 16'hFFFF, 3, 2'd1, -1);
        chk("frame_count after f0", 32'(frame_count), 32'd1);

        // Frame 1: image 1 under irregular ready, request out-of-range image.
        run_frame(1, 16'b1001_1100_0110_1010, 4, 2'd3, -1);
        chk("frame_count after f1", 32'(frame_count), 32'd2);

        // Frame 2: black, request image 0 back.
        run_frame(2, 16'b0101_1011_0010_1101, 6, 2'd0, -1);
        chk("frame_count after f2", 32'(frame_count), 32'd3);

        // Frame 3: white, stop at beat 5 and reset with image 1 requested.
        run_frame(0, 16'hFFFF, 2, 2'd1, 5);
        reset = 1'b1;
        ready = 1'b1;
        step();
        chk("mid reset valid", 32'(valid), 32'd0);
        chk("mid reset frame_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        step();
        run_frame(1, 16'hFFFF, -1, 2'd1, -1);
        chk("frame_count after restart", 32'(frame_count), 32'd1);

        // CH_BITS=3 instance held with ready low the whole time.
        chk("ch3 hold data", 32'(data1), 32'({8'hB6, 2'b00, 8'h6D, 2'b00, 8'h24, 2'b00}));
        chk("ch3 hold sop", 32'(sop1), 32'd1);
        chk("ch3 hold eop", 32'(eop1), 32'd0);
        chk("ch3 frame_count", 32'(frame_count1), 32'd0);

`ifdef VGA_TEST_PATTERN_EN
        for (int x = 0; x < 8; x++) begin
            logic [2:0] k;
            k = 3'(x);
            chk($sformatf("bar x%0d", x), 32'(data2), 32'(px(k[2], k[1], k[0])));
            chk($sformatf("bar sop x%0d", x), 32'(sop2), 32'(x == 0));
            chk($sformatf("bar eop x%0d", x), 32'(eop2), 32'(x == 7));
            ready2 = 1'b1;
            step();
        end
        chk("bar frame_count", 32'(frame_count2), 32'd1);
        chk("bar valid", 32'(valid2), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
